// File: rtl/cmp_unit_iter.sv
// -----------------------------------------------------------------------------
// cmp_unit_iter
// Iterative magnitude compare for the ALU. The captured operands are walked one
// DIGIT-bit slice per cycle, starting at the most significant slice. The walk
// stops at the first slice that differs, or after the last slice when all are
// equal. Start/ready/flag handshake; the result codes follow the ALU compare
// encoding (EQ=1, GT=2, LT=3, anything else 0).
//
// Optional feature macro: CMP_SIGNED_EN
//   When defined, a CMP_Signed input is added. With CMP_Signed=1 the operand
//   MSBs are inverted at capture, so the unsigned slice walk gives a two's
//   complement compare.
// -----------------------------------------------------------------------------
module cmp_unit_iter #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       ALU_FUN,
    input  logic             CMP_Enable,
`ifdef CMP_SIGNED_EN
    input  logic             CMP_Signed,
`endif
    output logic             CMP_Ready,
    output logic [WIDTH-1:0] CMP_OUT,
    output logic             CMP_Flag
);

    localparam int NDIG = WIDTH / DIGIT;
    // A single slice still needs a 1-bit counter so the select logic stays uniform.
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [1:0] FUN_NOP = 2'b00;
    localparam logic [1:0] FUN_EQ  = 2'b01;
    localparam logic [1:0] FUN_GT  = 2'b10;
    localparam logic [1:0] FUN_LT  = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic [WIDTH-1:0] a_q,     a_d;
    logic [WIDTH-1:0] b_q,     b_d;
    logic [1:0]       fun_q,   fun_d;
    logic [WIDTH-1:0] out_q,   out_d;
    logic             flag_q,  flag_d;

    logic             accept_s;
    logic [WIDTH-1:0] a_cap_s;
    logic [WIDTH-1:0] b_cap_s;
    logic [DIGIT-1:0] slice_a_s;
    logic [DIGIT-1:0] slice_b_s;
    logic             rel_gt_s;
    logic             rel_lt_s;
    logic             last_s;
    logic             decide_s;
    logic [1:0]       code_s;

    // Maps the requested function and the slice relation to the ALU result code.
    function automatic logic [1:0] cmp_code(input logic [1:0] fun,
                                            input logic       gt,
                                            input logic       lt);
        logic [1:0] code;
        case (fun)
            FUN_EQ:  code = (!gt && !lt) ? 2'd1 : 2'd0;
            FUN_GT:  code = gt ? 2'd2 : 2'd0;
            FUN_LT:  code = lt ? 2'd3 : 2'd0;
            default: code = 2'd0;
        endcase
        return code;
    endfunction

    assign accept_s = CMP_Enable && (state_q == ST_IDLE);

`ifdef CMP_SIGNED_EN
    // Flipping the sign bit turns two's complement into offset binary,
    // whose unsigned order equals the signed order.
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    // Operand conditioning at capture for the optional signed compare.
    always_comb begin
        if (CMP_Signed) begin
            a_cap_s = A ^ MSB_MASK;
            b_cap_s = B ^ MSB_MASK;
        end else begin
            a_cap_s = A;
            b_cap_s = B;
        end
    end
`else
    assign a_cap_s = A;
    assign b_cap_s = B;
`endif

    // Select the slice currently addressed by the counter (constant-index mux).
    always_comb begin
        slice_a_s = '0;
        slice_b_s = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (cnt_q == CW'(i)) begin
                slice_a_s = a_q[i*DIGIT +: DIGIT];
                slice_b_s = b_q[i*DIGIT +: DIGIT];
            end else begin
                slice_a_s = slice_a_s;
                slice_b_s = slice_b_s;
            end
        end
    end

    assign rel_gt_s = (slice_a_s > slice_b_s);
    assign rel_lt_s = (slice_a_s < slice_b_s);
    assign last_s   = (cnt_q == CW'(0));
    // NOP needs no walk; a differing slice or the last slice settles the relation.
    assign decide_s = (state_q == ST_RUN) &&
                      ((fun_q == FUN_NOP) || rel_gt_s || rel_lt_s || last_s);
    assign code_s   = cmp_code(fun_q, rel_gt_s, rel_lt_s);

    // FSM state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (decide_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: ready whenever idle, including the result-pulse cycle.
    always_comb begin
        case (state_q)
            ST_IDLE: CMP_Ready = 1'b1;
            ST_RUN:  CMP_Ready = 1'b0;
            default: CMP_Ready = 1'b0;
        endcase
    end

    // Datapath next-state: capture on accept, walk slices while running, publish result.
    always_comb begin
        cnt_d  = cnt_q;
        a_d    = a_q;
        b_d    = b_q;
        fun_d  = fun_q;
        out_d  = out_q;
        flag_d = 1'b0;
        if (accept_s) begin
            a_d   = a_cap_s;
            b_d   = b_cap_s;
            fun_d = ALU_FUN;
            cnt_d = CW'(NDIG - 1);
        end else if (decide_s) begin
            out_d  = WIDTH'(code_s);
            flag_d = 1'b1;
        end else if (state_q == ST_RUN) begin
            cnt_d = cnt_q - CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Datapath registers; reset clears captured operands, counter and result.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            fun_q  <= 2'b00;
            out_q  <= '0;
            flag_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            a_q    <= a_d;
            b_q    <= b_d;
            fun_q  <= fun_d;
            out_q  <= out_d;
            flag_q <= flag_d;
        end
    end

    assign CMP_OUT  = out_q;
    assign CMP_Flag = flag_q;

endmodule

// File: tb/tb_cmp_unit_iter.sv
// -----------------------------------------------------------------------------
// tb_cmp_unit_iter
// Three instances (DIGIT = 4, 16, 1) share operands; each has its own enable
// and its own scoreboard queue holding the expected code and the expected
// cycle of the result pulse. Honours CMP_SIGNED_EN for the signed case.
// -----------------------------------------------------------------------------
module tb_cmp_unit_iter;

    localparam int W = 16;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [1:0]   fun;
        logic         sgn;
        logic [W-1:0] exp;
        int           lat4;
        int           lat16;
        int           lat1;
    } vec_t;

    typedef struct {
        logic [W-1:0] out;
        int           cyc;
    } exp_t;

    logic         CLK = 1'b0;
    logic         RST;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [1:0]   FUN;
    logic [2:0]   en;
`ifdef CMP_SIGNED_EN
    logic         sgn;
`endif
    logic [W-1:0] out_w [3];
    logic [2:0]   flag_w;
    logic [2:0]   rdy_w;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    vec_t tbl[13];

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    cmp_unit_iter #(.WIDTH(W), .DIGIT(4)) u_d4 (
        .CLK(CLK), .RST(RST), .A(A), .B(B), .ALU_FUN(FUN), .CMP_Enable(en[0]),
`ifdef CMP_SIGNED_EN
        .CMP_Signed(sgn),
`endif
        .CMP_Ready(rdy_w[0]), .CMP_OUT(out_w[0]), .CMP_Flag(flag_w[0]));

    cmp_unit_iter #(.WIDTH(W), .DIGIT(16)) u_d16 (
        .CLK(CLK), .RST(RST), .A(A), .B(B), .ALU_FUN(FUN), .CMP_Enable(en[1]),
`ifdef CMP_SIGNED_EN
        .CMP_Signed(sgn),
`endif
        .CMP_Ready(rdy_w[1]), .CMP_OUT(out_w[1]), .CMP_Flag(flag_w[1]));

    cmp_unit_iter #(.WIDTH(W), .DIGIT(1)) u_d1 (
        .CLK(CLK), .RST(RST), .A(A), .B(B), .ALU_FUN(FUN), .CMP_Enable(en[2]),
`ifdef CMP_SIGNED_EN
        .CMP_Signed(sgn),
`endif
        .CMP_Ready(rdy_w[2]), .CMP_OUT(out_w[2]), .CMP_Flag(flag_w[2]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [1:0] fun, input logic s,
                                input logic [W-1:0] exp, input int l4,
                                input int l16, input int l1);
        vec_t v;
        v.a = a; v.b = b; v.fun = fun; v.sgn = s; v.exp = exp;
        v.lat4 = l4; v.lat16 = l16; v.lat1 = l1;
        return v;
    endfunction

    function automatic int lat_of(input vec_t v, input int k);
        case (k)
            0:       return v.lat4;
            1:       return v.lat16;
            default: return v.lat1;
        endcase
    endfunction

    function automatic int sb_size(input int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic sb_push(input int k, input exp_t e);
        case (k)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic sb_pop(input int k, output exp_t e);
        case (k)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
    endtask

    // Result monitor: every flag pulse must match the head of that instance's queue.
    always @(negedge CLK) begin
        if (RST === 1'b0) begin
            for (int k = 0; k < 3; k++) begin
                if (flag_w[k] === 1'b1) begin
                    if (sb_size(k) == 0) begin
                        check($sformatf("d%0d_spurious_flag", k), {31'd0, flag_w[k]}, 32'd0);
                    end else begin
                        exp_t e;
                        sb_pop(k, e);
                        check($sformatf("d%0d_out", k), {16'd0, out_w[k]}, {16'd0, e.out});
                        check($sformatf("d%0d_flag_cycle", k), cyc, e.cyc);
                        check($sformatf("d%0d_ready_in_flag", k), {31'd0, rdy_w[k]}, 32'd1);
                    end
                end
            end
        end
    end

    // Called at a negedge; returns at a negedge. Enable stays high for 'hold' cycles.
    task automatic issue(input vec_t v, input logic [2:0] mask, input int hold, output int t_drv);
        int n = 0;
        while (((rdy_w & mask) != mask) && (n < 200)) begin
            @(negedge CLK);
            n++;
        end
        check("ready_wait", {29'd0, rdy_w & mask}, {29'd0, mask});
        A   = v.a;
        B   = v.b;
        FUN = v.fun;
`ifdef CMP_SIGNED_EN
        sgn = v.sgn;
`endif
        en  = mask;
        t_drv = cyc;
        for (int k = 0; k < 3; k++) begin
            if (mask[k]) begin
                exp_t e;
                e.out = v.exp;
                e.cyc = cyc + 1 + lat_of(v, k);
                sb_push(k, e);
            end
        end
        repeat (hold) @(negedge CLK);
        en = 3'b000;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (((q0.size() + q1.size() + q2.size()) != 0) && (n < 300)) begin
            @(negedge CLK);
            n++;
        end
        check("drain", q0.size() + q1.size() + q2.size(), 32'd0);
        @(negedge CLK);
    endtask

    initial begin
        int   t1;
        int   t2;
        vec_t v_eq;
        vec_t v_lt;

        // in: a, b, fun, signed; expected code; latency for DIGIT 4 / 16 / 1
        tbl[0]  = mk(16'h1234, 16'h1234, 2'b01, 1'b0, 16'd1, 4, 1, 16);
        tbl[1]  = mk(16'h9000, 16'h1FFF, 2'b10, 1'b0, 16'd2, 1, 1, 1);
        tbl[2]  = mk(16'h9000, 16'h1FFF, 2'b11, 1'b0, 16'd0, 1, 1, 1);
        tbl[3]  = mk(16'h1230, 16'h1231, 2'b11, 1'b0, 16'd3, 4, 1, 16);
        tbl[4]  = mk(16'h1230, 16'h1231, 2'b10, 1'b0, 16'd0, 4, 1, 16);
        tbl[5]  = mk(16'h1234, 16'h1234, 2'b00, 1'b0, 16'd0, 1, 1, 1);
        tbl[6]  = mk(16'h1234, 16'h1234, 2'b10, 1'b0, 16'd0, 4, 1, 16);
        tbl[7]  = mk(16'h0000, 16'h0000, 2'b01, 1'b0, 16'd1, 4, 1, 16);
        tbl[8]  = mk(16'hFFFF, 16'h0001, 2'b11, 1'b0, 16'd0, 1, 1, 1);
        tbl[9]  = mk(16'h00F0, 16'h0100, 2'b11, 1'b0, 16'd3, 2, 1, 8);
        tbl[10] = mk(16'h1234, 16'h1235, 2'b01, 1'b0, 16'd0, 4, 1, 16);
        tbl[11] = mk(16'hABCD, 16'h1BCD, 2'b10, 1'b0, 16'd2, 1, 1, 1);
`ifdef CMP_SIGNED_EN
        tbl[12] = mk(16'hFFFF, 16'h0001, 2'b11, 1'b1, 16'd3, 1, 1, 1);
`else
        tbl[12] = mk(16'hFFFF, 16'h0001, 2'b11, 1'b1, 16'd0, 1, 1, 1);
`endif

        RST = 1'b1;
        A   = 16'h0000;
        B   = 16'h0000;
        FUN = 2'b00;
        en  = 3'b000;
`ifdef CMP_SIGNED_EN
        sgn = 1'b0;
`endif
        repeat (3) @(negedge CLK);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("d%0d_rst_ready", k), {31'd0, rdy_w[k]}, 32'd1);
            check($sformatf("d%0d_rst_out", k), {16'd0, out_w[k]}, 32'd0);
            check($sformatf("d%0d_rst_flag", k), {31'd0, flag_w[k]}, 32'd0);
        end
        RST = 1'b0;
        @(negedge CLK);

        // Table-driven compares on all three slice widths.
        for (int i = 0; i < 13; i++) begin
            issue(tbl[i], 3'b111, 1, t1);
            wait_idle();
        end

        // Flag is a single pulse and the code is held afterwards.
        v_eq = tbl[0];
        issue(v_eq, 3'b001, 1, t1);
        wait_idle();
        @(negedge CLK);
        check("d4_flag_low_after", {31'd0, flag_w[0]}, 32'd0);
        check("d4_out_held", {16'd0, out_w[0]}, 32'd1);

        // Back-to-back: second accept lands in the flag cycle (t0+L+1).
        v_lt = tbl[3];
        for (int k = 0; k < 3; k++) begin
            issue(v_eq, 3'(1 << k), 1, t1);
            issue(v_lt, 3'(1 << k), 1, t2);
            check($sformatf("d%0d_b2b_accept", k), t2, t1 + 1 + lat_of(v_eq, k));
            wait_idle();
        end

        // Enable held through the whole run: exactly one result per instance.
        for (int k = 0; k < 3; k++) begin
            issue(v_eq, 3'(1 << k), lat_of(v_eq, k) + 1, t1);
            wait_idle();
            repeat (40) @(negedge CLK);
            check($sformatf("d%0d_busy_single", k), sb_size(k), 32'd0);
        end

        // Reset two cycles into an EQ run aborts it.
        issue(v_eq, 3'b111, 1, t1);
        @(posedge CLK);
        #1 RST = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("d%0d_midrst_ready", k), {31'd0, rdy_w[k]}, 32'd1);
            check($sformatf("d%0d_midrst_out", k), {16'd0, out_w[k]}, 32'd0);
            check($sformatf("d%0d_midrst_flag", k), {31'd0, flag_w[k]}, 32'd0);
        end
        q0.delete();
        q1.delete();
        q2.delete();
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        repeat (25) @(negedge CLK);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("d%0d_postrst_out", k), {16'd0, out_w[k]}, 32'd0);
            check($sformatf("d%0d_postrst_ready", k), {31'd0, rdy_w[k]}, 32'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
